// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU opcode, resolves forwarded operands
// and holds them for the ALU behind a valid/ready handshake.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [4:0]       rd_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_class,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             reg_write,
    input  logic             flush,
    input  logic             exm_wr_en,
    input  logic [4:0]       exm_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic             mwb_wr_en,
    input  logic [4:0]       mwb_rd,
    input  logic [XLEN-1:0]  mwb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ex_ain,
    output logic [XLEN-1:0]  ex_bin,
    output logic [3:0]       ex_aluop,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic            load;
    logic [3:0]      aluop_d;
    logic            illegal_d;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            e_en,
        input logic [4:0]      e_rd,
        input logic [XLEN-1:0] e_data,
        input logic            m_en,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data
    );
        if (addr == 5'd0)
            return '0;
        else if (e_en && (e_rd == addr))
            return e_data;
        else if (m_en && (m_rd == addr))
            return m_data;
        else
            return rf_data;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    assign rs1_fwd = forward(rs1_addr, rs1_data, exm_wr_en, exm_rd, exm_data,
                             mwb_wr_en, mwb_rd, mwb_data);
    assign rs2_fwd = forward(rs2_addr, rs2_data, exm_wr_en, exm_rd, exm_data,
                             mwb_wr_en, mwb_rd, mwb_data);

    always_comb begin
        aluop_d   = OP_ILL;
        illegal_d = 1'b1;
        case (alu_class)
            2'b00: begin
                aluop_d   = OP_ADD;
                illegal_d = 1'b0;
            end
            2'b01: begin
                aluop_d   = OP_SUB;
                illegal_d = 1'b0;
            end
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        aluop_d   = funct7_5 ? OP_SUB : OP_ADD;
                        illegal_d = 1'b0;
                    end
                    3'b110: begin
                        aluop_d   = OP_OR;
                        illegal_d = 1'b0;
                    end
                    3'b111: begin
                        aluop_d   = OP_AND;
                        illegal_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000: begin
                        aluop_d   = OP_ADD;
                        illegal_d = 1'b0;
                    end
                    3'b110: begin
                        aluop_d   = OP_OR;
                        illegal_d = 1'b0;
                    end
                    3'b111: begin
                        aluop_d   = OP_AND;
                        illegal_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            ex_ain       <= '0;
            ex_bin       <= '0;
            ex_aluop     <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid    <= 1'b1;
                ex_ain       <= rs1_fwd;
                ex_bin       <= alu_src ? imm : rs2_fwd;
                ex_aluop     <= aluop_d;
                ex_rd        <= rd_addr;
                ex_reg_write <= reg_write && !illegal_d;
                ex_illegal   <= illegal_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; stall counter narrowed so saturation is reachable.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0]  rs1_data, rs2_data, imm;
    logic             alu_src;
    logic [1:0]       alu_class;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             reg_write;
    logic             flush;
    logic             exm_wr_en;
    logic [4:0]       exm_rd;
    logic [XLEN-1:0]  exm_data;
    logic             mwb_wr_en;
    logic [4:0]       mwb_rd;
    logic [XLEN-1:0]  mwb_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ex_ain, ex_bin;
    logic [3:0]       ex_aluop;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_illegal;
    logic [CNT_W-1:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_src(alu_src), .alu_class(alu_class), .funct3(funct3),
        .funct7_5(funct7_5), .reg_write(reg_write), .flush(flush),
        .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_ain(ex_ain), .ex_bin(ex_bin), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] a1, input logic [XLEN-1:0] d1,
                        input logic [4:0] a2, input logic [XLEN-1:0] d2,
                        input logic [1:0] cls, input logic [2:0] f3, input logic f7);
        in_valid  = 1'b1;
        rs1_addr  = a1;
        rs1_data  = d1;
        rs2_addr  = a2;
        rs2_data  = d2;
        alu_class = cls;
        funct3    = f3;
        funct7_5  = f7;
    endtask

    // {class, funct3, funct7_5, expected opcode, expected illegal}
    logic [10:0] op_tab [8] = '{
        {2'b10, 3'b000, 1'b0, 4'b0010, 1'b0},
        {2'b10, 3'b110, 1'b1, 4'b0001, 1'b0},
        {2'b10, 3'b111, 1'b0, 4'b0000, 1'b0},
        {2'b10, 3'b010, 1'b0, 4'b1111, 1'b1},
        {2'b01, 3'b101, 1'b1, 4'b0110, 1'b0},
        {2'b00, 3'b011, 1'b1, 4'b0010, 1'b0},
        {2'b11, 3'b110, 1'b0, 4'b0001, 1'b0},
        {2'b11, 3'b111, 1'b1, 4'b0000, 1'b0}
    };

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        alu_src = 1'b0; alu_class = '0; funct3 = '0; funct7_5 = 1'b0; reg_write = 1'b0;
        exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wr_en = 1'b0; mwb_rd = '0; mwb_data = '0;
        tick; tick;
        check("rst_valid", out_valid, 0);
        check("rst_aluop", ex_aluop, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // R-type SUB, register-file operands
        beat(5'd1, 32'd5, 5'd2, 32'd3, 2'b10, 3'b000, 1'b1);
        rd_addr = 5'd4; reg_write = 1'b1;
        tick;
        check("sub_valid", out_valid, 1);
        check("sub_ain", ex_ain, 5);
        check("sub_bin", ex_bin, 3);
        check("sub_aluop", ex_aluop, 4'b0110);
        check("sub_rd", ex_rd, 4);
        check("sub_rw", ex_reg_write, 1);
        check("sub_ill", ex_illegal, 0);

        // forwarding priority
        beat(5'd7, 32'h1, 5'd7, 32'h2, 2'b10, 3'b000, 1'b0);
        exm_wr_en = 1'b1; exm_rd = 5'd7; exm_data = 32'hAA;
        mwb_wr_en = 1'b1; mwb_rd = 5'd7; mwb_data = 32'hBB;
        tick;
        check("fwd_exm_ain", ex_ain, 32'hAA);
        check("fwd_exm_bin", ex_bin, 32'hAA);
        rs1_addr = 5'd0; exm_rd = 5'd0;
        tick;
        check("fwd_x0_ain", ex_ain, 0);
        check("fwd_mwb_bin", ex_bin, 32'hBB);
        exm_wr_en = 1'b0; mwb_wr_en = 1'b0;

        // backpressure
        beat(5'd3, 32'h11, 5'd5, 32'h22, 2'b00, 3'b000, 1'b0);
        tick;
        check("bp_load_ain", ex_ain, 32'h11);
        check("bp_load_op", ex_aluop, 4'b0010);
        beat(5'd3, 32'h99, 5'd5, 32'h77, 2'b01, 3'b000, 1'b0);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            tick;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ain", ex_ain, 32'h11);
            check("bp_hold_bin", ex_bin, 32'h22);
            check("bp_hold_op", ex_aluop, 4'b0010);
        end
        check("bp_stall4", stall_cnt, 4);
        out_ready = 1'b1;
        tick;
        check("bp_b2b_valid", out_valid, 1);
        check("bp_b2b_ain", ex_ain, 32'h99);
        check("bp_b2b_op", ex_aluop, 4'b0110);
        check("bp_stall_keep", stall_cnt, 4);

        // flush with a beat offered
        beat(5'd3, 32'h55, 5'd5, 32'h66, 2'b00, 3'b000, 1'b0);
        flush = 1'b1;
        tick;
        check("fl_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick;
        check("fl_valid2", out_valid, 0);
        check("fl_stall", stall_cnt, 4);

        // drain without reload
        beat(5'd3, 32'h12, 5'd5, 32'h34, 2'b00, 3'b000, 1'b0);
        tick;
        check("dr_load", out_valid, 1);
        in_valid = 1'b0;
        tick;
        check("dr_empty", out_valid, 0);

        // illegal decode and immediate select
        beat(5'd3, 32'h1, 5'd5, 32'h2, 2'b11, 3'b001, 1'b0);
        reg_write = 1'b1;
        tick;
        check("ill_op", ex_aluop, 4'b1111);
        check("ill_flag", ex_illegal, 1);
        check("ill_rw", ex_reg_write, 0);
        beat(5'd3, 32'h1, 5'd5, 32'h2, 2'b11, 3'b000, 1'b1);
        alu_src = 1'b1; imm = 32'hFFFF_FFFF;
        tick;
        check("imm_op", ex_aluop, 4'b0010);
        check("imm_bin", ex_bin, 32'hFFFF_FFFF);
        check("imm_ill", ex_illegal, 0);
        check("imm_rw", ex_reg_write, 1);
        alu_src = 1'b0;

        // opcode table
        for (int unsigned i = 0; i < 8; i++) begin
            logic [10:0] e;
            e = op_tab[i];
            beat(5'd3, 32'h1, 5'd5, 32'h2, e[10:9], e[8:6], e[5]);
            tick;
            check("tab_op", ex_aluop, e[4:1]);
            check("tab_ill", ex_illegal, e[0]);
            check("tab_rw", ex_reg_write, !e[0]);
        end

        // saturation then reset mid-hold
        out_ready = 1'b0; in_valid = 1'b0;
        for (int unsigned i = 0; i < 20; i++) tick;
        check("sat_stall", stall_cnt, 15);
        check("sat_valid", out_valid, 1);
        rst_n = 1'b0;
        tick;
        check("rh_valid", out_valid, 0);
        check("rh_stall", stall_cnt, 0);
        check("rh_aluop", ex_aluop, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick;
        check("rh_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Accepts one decoded instruction per beat over a valid/ready handshake and translates the decode class and funct fields into the 4-bit ALU opcode.
- Resolves rs1/rs2 operands by forwarding from the EX/MEM and MEM/WB stages, applies the immediate select, and registers Ain, Bin and ALUop for the ALU.
- Handles backpressure, flush and a saturating stall counter.

Parameters:
- XLEN, 32, operand and data width; must match ALU Ain/Bin width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- rs1_addr, rs2_addr, rd_addr  in  5 each  register indices.
- rs1_data, rs2_data  in  XLEN each  register file read data.
- imm  in  XLEN  sign-extended immediate.
- alu_src  in  1  1 = Bin takes imm, 0 = Bin takes forwarded rs2.
- alu_class  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- reg_write  in  1  instruction writes rd.
- flush  in  1  kill the held entry and any beat offered this cycle.
- exm_wr_en, exm_rd, exm_data  in  1/5/XLEN  EX/MEM forwarding source.
- mwb_wr_en, mwb_rd, mwb_data  in  1/5/XLEN  MEM/WB forwarding source.
- out_valid  out  1  entry valid toward the ALU.
- out_ready  in  1  downstream consumes the entry.
- ex_ain, ex_bin  out  XLEN each  registered ALU operands.
- ex_aluop  out  4  registered ALU opcode.
- ex_rd  out  5  registered destination register.
- ex_reg_write  out  1  registered write enable; forced 0 when illegal.
- ex_illegal  out  1  registered unsupported-operation flag.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all outputs and registers clear to 0 (out_valid=0, ex_aluop=4'b0000, stall_cnt=0). Reset mid-transfer discards the held entry.
- State: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid | out_ready. This is combinational and independent of flush.
- Load: when in_valid & in_ready & !flush, capture next cycle and set out_valid=1. Latency is 1 cycle.
- Drain: out_valid & out_ready with no load clears out_valid. Consume and load in the same cycle keeps FULL with the new contents (back-to-back, full throughput).
- Hold: while out_valid & !out_ready, all ex_* outputs stay bit-stable.
- Flush: highest priority. Next cycle out_valid=0, and a beat offered the same cycle is dropped. Data registers may keep stale values.
- Forwarding per operand, evaluated at capture only:
  - addr==0 gives 0.
  - else if exm_wr_en & exm_rd==addr, use exm_data (EX/MEM wins).
  - else if mwb_wr_en & mwb_rd==addr, use mwb_data.
  - else use the register file data.
- ex_ain = forwarded rs1. ex_bin = alu_src ? imm : forwarded rs2.
- ALU opcode map:
  - class 00 gives 0010 (ADD).
  - class 01 gives 0110 (SUB).
  - class 10: funct3 000 gives 0010 when funct7_5=0 and 0110 when funct7_5=1; 110 gives 0001 (OR); 111 gives 0000 (AND).
  - class 11: 000 gives 0010 (funct7_5 ignored); 110 gives 0001; 111 gives 0000.
  - Any other combination: ex_aluop=4'b1111, ex_illegal=1, ex_reg_write=0.
- stall_cnt increments each cycle out_valid & !out_ready and saturates at all-ones. It is not cleared by flush.

Test Plan:
- After reset: beat rs1_data=5, rs2_data=3, class 10, funct3 000, funct7_5=1, out_ready=1 -> next cycle out_valid=1, ex_ain=5, ex_bin=3, ex_aluop=0110.
- Forwarding priority: rs1_addr=rs2_addr=7, exm_wr_en=1, exm_rd=7, exm_data=0xAA, mwb_wr_en=1, mwb_rd=7, mwb_data=0xBB -> ex_ain=ex_bin=0xAA. Same beat with rs1_addr=0 and exm_rd=0 -> ex_ain=0.
- Backpressure: out_ready=0 for 4 cycles while FULL -> in_ready=0, outputs stable, stall_cnt=4. Then out_ready=1 with a new beat -> new contents in 1 cycle with no bubble.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, and the offered beat never appears.
- Illegal decode: class 11, funct3 001 -> ex_aluop=1111, ex_illegal=1, ex_reg_write=0. Class 11, funct3 000, funct7_5=1, imm=0xFFFFFFFF, alu_src=1 -> ex_aluop=0010, ex_bin=0xFFFFFFFF.
- Reset mid-hold: rst_n=0 while FULL and stalled -> next cycle out_valid=0, stall_cnt=0, ex_aluop=0000.
